// File: rtl/signed_arithmetic_fpga.sv
// signed_arithmetic_fpga
// Two's-complement sum and product of two W-bit operands, each computed twice:
// once with the native signed operators and once with an explicit structural
// datapath (ripple-carry adder, shift-and-add multiplier). Matching result pairs
// let a bench or board-level check confirm the synthesis tool's signed handling.
// All four results are registered with exactly one cycle of latency. A
// synchronous active-high reset clears them.

module signed_arithmetic_fpga #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W:0]     add1,
  output logic [W:0]     add2,
  output logic [2*W-1:0] mul1,
  output logic [2*W-1:0] mul2
);

  // ---------------------------------------------------------------------------
  // Native signed path
  // ---------------------------------------------------------------------------
  // The operands are sign-extended into signed containers of the result width.
  // This keeps the operators working at full width. The sum then never wraps,
  // and the product keeps the (-2^(W-1))^2 corner positive.
  logic signed [W:0]     a_sx_s;
  logic signed [W:0]     b_sx_s;
  logic signed [W:0]     add1_s;
  logic signed [2*W-1:0] a_mx_s;
  logic signed [2*W-1:0] b_mx_s;
  logic signed [2*W-1:0] mul1_s;

  assign a_sx_s = {a[W-1], a};
  assign b_sx_s = {b[W-1], b};
  assign add1_s = a_sx_s + b_sx_s;

  assign a_mx_s = {{W{a[W-1]}}, a};
  assign b_mx_s = {{W{b[W-1]}}, b};
  assign mul1_s = a_mx_s * b_mx_s;

  // ---------------------------------------------------------------------------
  // Structural sum: sign-extend by one bit, then a bitwise ripple-carry chain
  // over plain unsigned vectors. The carry out of the top bit is discarded.
  // The W+1-bit result is exact because both inputs were widened first.
  // ---------------------------------------------------------------------------
  logic [W:0] a_ux_s;
  logic [W:0] b_ux_s;
  logic [W:0] add2_s;

  assign a_ux_s = {a[W-1], a};
  assign b_ux_s = {b[W-1], b};

  // Ripple-carry adder built from per-bit full-adder equations
  always_comb begin
    logic carry_v;
    carry_v = 1'b0;
    add2_s  = {(W+1){1'b0}};
    for (int i = 0; i <= W; i++) begin
      add2_s[i] = a_ux_s[i] ^ b_ux_s[i] ^ carry_v;
      carry_v   = (a_ux_s[i] & b_ux_s[i]) | (carry_v & (a_ux_s[i] ^ b_ux_s[i]));
    end
  end

  // ---------------------------------------------------------------------------
  // Structural product: shift-and-add over sign-extended partial products.
  // Bit i of b (i < W-1) has weight +2^i, so its partial product is added.
  // The sign bit b[W-1] has weight -2^(W-1), so its partial product is
  // subtracted. Everything is accumulated modulo 2^(2W), and that is exact for
  // every operand pair because the true product always fits in 2W bits.
  // ---------------------------------------------------------------------------
  logic [2*W-1:0]          a_ext_s;
  logic [W-1:0][2*W-1:0]   pp_s;
  logic [2*W-1:0]          mul2_s;

  assign a_ext_s = {{W{a[W-1]}}, a};

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_pp
      assign pp_s[gi] = b[gi] ? (a_ext_s << gi) : {(2*W){1'b0}};
    end
  endgenerate

  // Accumulate the positive-weight partial products, then subtract the sign-bit one
  always_comb begin
    logic [2*W-1:0] acc_v;
    acc_v = {(2*W){1'b0}};
    for (int i = 0; i < W-1; i++) begin
      acc_v = acc_v + pp_s[i];
    end
    mul2_s = acc_v - pp_s[W-1];
  end

  // ---------------------------------------------------------------------------
  // Output registers. These are the only state in the block, so holding the
  // inputs steady holds the outputs steady.
  // ---------------------------------------------------------------------------
  logic [W:0]     add1_r;
  logic [W:0]     add2_r;
  logic [2*W-1:0] mul1_r;
  logic [2*W-1:0] mul2_r;

  // Capture all four results each edge; a synchronous reset clears them and takes priority
  always_ff @(posedge clk) begin
    if (reset) begin
      add1_r <= {(W+1){1'b0}};
      add2_r <= {(W+1){1'b0}};
      mul1_r <= {(2*W){1'b0}};
      mul2_r <= {(2*W){1'b0}};
    end else begin
      add1_r <= add1_s;
      add2_r <= add2_s;
      mul1_r <= mul1_s;
      mul2_r <= mul2_s;
    end
  end

  assign add1 = add1_r;
  assign add2 = add2_r;
  assign mul1 = mul1_r;
  assign mul2 = mul2_r;

endmodule

// File: tb/tb_signed_arithmetic_fpga.sv
// Self-checking bench for signed_arithmetic_fpga (W = 8).
// Directed vectors with hand-computed results, reset behaviour, back-to-back
// and hold cycles, then a full sweep of all 65536 operand pairs against an
// integer model with a reset pulse part-way through.

module tb_signed_arithmetic_fpga;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W:0]     add1;
  logic [W:0]     add2;
  logic [2*W-1:0] mul1;
  logic [2*W-1:0] mul2;

  int errors;
  int checks;

  signed_arithmetic_fpga #(.W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .add1 (add1),
    .add2 (add2),
    .mul1 (mul1),
    .mul2 (mul2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then let one rising edge pass and sample 1ns later
  task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv, input logic rv);
    @(negedge clk);
    a     = av;
    b     = bv;
    reset = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(8'h3C, 8'hA5, 1'b1);
    checks++; if (add1 !== 9'h000) begin errors++; $display("FAIL reset_add1 got %h want %h", add1, 9'h000); end
    checks++; if (add2 !== 9'h000) begin errors++; $display("FAIL reset_add2 got %h want %h", add2, 9'h000); end
    checks++; if (mul1 !== 16'h0000) begin errors++; $display("FAIL reset_mul1 got %h want %h", mul1, 16'h0000); end
    checks++; if (mul2 !== 16'h0000) begin errors++; $display("FAIL reset_mul2 got %h want %h", mul2, 16'h0000); end
  endtask

  task automatic test_directed();
    logic [W-1:0]   va [10];
    logic [W-1:0]   vb [10];
    logic [W:0]     vs [10];
    logic [2*W-1:0] vm [10];
    va[0] = 8'hFB; vb[0] = 8'h0A; vs[0] = 9'h005; vm[0] = 16'hFFCE; // -5*10
    va[1] = 8'h80; vb[1] = 8'hFF; vs[1] = 9'h17F; vm[1] = 16'h0080; // -128*-1
    va[2] = 8'h14; vb[2] = 8'h0F; vs[2] = 9'h023; vm[2] = 16'h012C; // 20*15
    va[3] = 8'h80; vb[3] = 8'h80; vs[3] = 9'h100; vm[3] = 16'h4000; // -128*-128
    va[4] = 8'h7F; vb[4] = 8'h7F; vs[4] = 9'h0FE; vm[4] = 16'h3F01; // 127*127
    va[5] = 8'h7F; vb[5] = 8'h80; vs[5] = 9'h1FF; vm[5] = 16'hC080; // 127*-128
    va[6] = 8'hFF; vb[6] = 8'hFF; vs[6] = 9'h1FE; vm[6] = 16'h0001; // -1*-1
    va[7] = 8'h00; vb[7] = 8'h80; vs[7] = 9'h180; vm[7] = 16'h0000; // 0*-128
    va[8] = 8'h80; vb[8] = 8'h01; vs[8] = 9'h181; vm[8] = 16'hFF80; // -128*1
    va[9] = 8'h0A; vb[9] = 8'hF6; vs[9] = 9'h000; vm[9] = 16'hFF9C; // 10*-10
    for (int i = 0; i < 10; i++) begin
      step(va[i], vb[i], 1'b0);
      checks++; if (add1 !== vs[i]) begin errors++; $display("FAIL dir%0d_add1 got %h want %h", i, add1, vs[i]); end
      checks++; if (add2 !== vs[i]) begin errors++; $display("FAIL dir%0d_add2 got %h want %h", i, add2, vs[i]); end
      checks++; if (mul1 !== vm[i]) begin errors++; $display("FAIL dir%0d_mul1 got %h want %h", i, mul1, vm[i]); end
      checks++; if (mul2 !== vm[i]) begin errors++; $display("FAIL dir%0d_mul2 got %h want %h", i, mul2, vm[i]); end
    end
  endtask

  task automatic test_back_to_back();
    // Change inputs every cycle: each edge must show only the pair applied just before it
    step(8'h14, 8'h0F, 1'b0);
    step(8'hFB, 8'h0A, 1'b0);
    checks++; if (add1 !== 9'h005) begin errors++; $display("FAIL b2b_add1 got %h want %h", add1, 9'h005); end
    checks++; if (mul2 !== 16'hFFCE) begin errors++; $display("FAIL b2b_mul2 got %h want %h", mul2, 16'hFFCE); end
    // Holding the inputs must hold the outputs
    step(8'hFB, 8'h0A, 1'b0);
    checks++; if (add2 !== 9'h005) begin errors++; $display("FAIL hold_add2 got %h want %h", add2, 9'h005); end
    checks++; if (mul1 !== 16'hFFCE) begin errors++; $display("FAIL hold_mul1 got %h want %h", mul1, 16'hFFCE); end
  endtask

  task automatic test_reset_priority();
    step(8'hFB, 8'h0A, 1'b1);
    checks++; if (add1 !== 9'h000) begin errors++; $display("FAIL rstpri_add1 got %h want %h", add1, 9'h000); end
    checks++; if (add2 !== 9'h000) begin errors++; $display("FAIL rstpri_add2 got %h want %h", add2, 9'h000); end
    checks++; if (mul1 !== 16'h0000) begin errors++; $display("FAIL rstpri_mul1 got %h want %h", mul1, 16'h0000); end
    checks++; if (mul2 !== 16'h0000) begin errors++; $display("FAIL rstpri_mul2 got %h want %h", mul2, 16'h0000); end
    step(8'hFB, 8'h0A, 1'b0);
    checks++; if (add1 !== 9'h005) begin errors++; $display("FAIL rstrel_add1 got %h want %h", add1, 9'h005); end
    checks++; if (add2 !== 9'h005) begin errors++; $display("FAIL rstrel_add2 got %h want %h", add2, 9'h005); end
    checks++; if (mul1 !== 16'hFFCE) begin errors++; $display("FAIL rstrel_mul1 got %h want %h", mul1, 16'hFFCE); end
    checks++; if (mul2 !== 16'hFFCE) begin errors++; $display("FAIL rstrel_mul2 got %h want %h", mul2, 16'hFFCE); end
  endtask

  task automatic test_exhaustive();
    int             sa;
    int             sb;
    logic [W-1:0]   av;
    logic [W-1:0]   bv;
    logic [W:0]     es;
    logic [2*W-1:0] em;
    for (int i = 0; i < 65536; i++) begin
      av = i[7:0];
      bv = i[15:8];
      if (i == 30000) begin
        // Mid-sweep reset pulse: outputs clear regardless of the pair applied
        step(av, bv, 1'b1);
        checks++; if (add1 !== 9'h000 || add2 !== 9'h000 || mul1 !== 16'h0000 || mul2 !== 16'h0000) begin
          errors++;
          $display("FAIL sweep_reset got %h %h %h %h want all zero", add1, add2, mul1, mul2);
        end
      end
      sa = $signed(av);
      sb = $signed(bv);
      es = 9'(sa + sb);
      em = 16'(sa * sb);
      step(av, bv, 1'b0);
      checks++; if (add1 !== es) begin errors++; $display("FAIL sweep_add1 a=%0d b=%0d got %h want %h", sa, sb, add1, es); end
      checks++; if (add2 !== es) begin errors++; $display("FAIL sweep_add2 a=%0d b=%0d got %h want %h", sa, sb, add2, es); end
      checks++; if (mul1 !== em) begin errors++; $display("FAIL sweep_mul1 a=%0d b=%0d got %h want %h", sa, sb, mul1, em); end
      checks++; if (mul2 !== em) begin errors++; $display("FAIL sweep_mul2 a=%0d b=%0d got %h want %h", sa, sb, mul2, em); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    a      = 8'h00;
    b      = 8'h00;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_priority();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
